// File: rtl/hci_mem_bank_responder_if.sv
// HCI memory-bank request/response bundle: request channel from the master,
// grant and in-order response channel back from the bank.
interface hci_mem_bank_responder_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 10,
  parameter int unsigned IW = 20
);
  logic              req;
  logic              gnt;
  logic              wen;
  logic [DW/8-1:0]   be;
  logic [AW-1:0]     add;
  logic [DW-1:0]     data;
  logic [IW-1:0]     id;
  logic              r_valid;
  logic [DW-1:0]     r_data;
  logic [IW-1:0]     r_id;

  modport master (
    output req, wen, be, add, data, id,
    input  gnt, r_valid, r_data, r_id
  );

  modport slave (
    input  req, wen, be, add, data, id,
    output gnt, r_valid, r_data, r_id
  );
endinterface

// File: rtl/hci_mem_bank_responder.sv
// Single-port HCI memory bank with fixed-latency in-order responses.
// Define HCI_MEM_RESP_STALL_EN to inject a periodic one-cycle grant stall.
module hci_mem_bank_responder #(
  parameter int unsigned DW           = 32,
  parameter int unsigned AW           = 10,
  parameter int unsigned IW           = 20,
  parameter int unsigned LATENCY      = 1,
  parameter int unsigned STALL_PERIOD = 8
) (
  input logic                   clk_i,
  input logic                   rst_i,
  input logic                   clear_i,
  hci_mem_bank_responder_if.slave bus
);

  localparam int unsigned BW    = DW / 8;
  localparam int unsigned Depth = 2 ** AW;

  if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
    $error("hci_mem_bank_responder: LATENCY must be in 1..4");
  end
  if (STALL_PERIOD < 2 || STALL_PERIOD > 255) begin : g_bad_stall
    $error("hci_mem_bank_responder: STALL_PERIOD must be in 2..255");
  end
  if (DW == 0 || (DW % 8) != 0) begin : g_bad_dw
    $error("hci_mem_bank_responder: DW must be a non-zero multiple of 8");
  end

  logic stall;
  logic xfer;

`ifdef HCI_MEM_RESP_STALL_EN
  localparam logic [7:0] StallLast = 8'(STALL_PERIOD - 1);
  logic [7:0] stall_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      stall_cnt_q <= '0;
    end else if (stall_cnt_q == StallLast) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_q + 8'd1;
    end
  end

  assign stall = (stall_cnt_q == StallLast);
`else
  assign stall = 1'b0;
`endif

  assign bus.gnt = bus.req & ~stall & ~clear_i & ~rst_i;
  assign xfer    = bus.gnt;

  // Memory is intentionally never reset.
  logic [DW-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (xfer && !bus.wen) begin
      for (int b = 0; b < BW; b++) begin
        if (bus.be[b]) begin
          mem_q[bus.add][b*8 +: 8] <= bus.data[b*8 +: 8];
        end
      end
    end
  end

  // Stage 0 is loaded at the end of the grant cycle; invalid stages carry zeros.
  logic          vld_q [LATENCY];
  logic [IW-1:0] id_q  [LATENCY];
  logic [DW-1:0] dat_q [LATENCY];

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      for (int i = 0; i < LATENCY; i++) begin
        vld_q[i] <= 1'b0;
        id_q[i]  <= '0;
        dat_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= xfer;
      id_q[0]  <= xfer ? bus.id : '0;
      dat_q[0] <= (xfer && bus.wen) ? mem_q[bus.add] : '0;
      for (int i = 1; i < LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        id_q[i]  <= id_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign bus.r_valid = vld_q[LATENCY-1];
  assign bus.r_id    = id_q[LATENCY-1];
  assign bus.r_data  = dat_q[LATENCY-1];

endmodule

// File: tb/tb_hci_mem_bank_responder.sv
// Directed bench for hci_mem_bank_responder: LATENCY 1/2/3 instances, plus a
// stall-period instance when HCI_MEM_RESP_STALL_EN is defined.
module tb_hci_mem_bank_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic clr1, clr3, clr2;
  int   checks   = 0;
  int   failures = 0;

  hci_mem_bank_responder_if #(.DW(32), .AW(10), .IW(20)) b1 ();
  hci_mem_bank_responder_if #(.DW(32), .AW(10), .IW(20)) b3 ();
  hci_mem_bank_responder_if #(.DW(32), .AW(10), .IW(20)) b2 ();

  hci_mem_bank_responder #(.DW(32), .AW(10), .IW(20), .LATENCY(1), .STALL_PERIOD(255)) u_l1 (
    .clk_i(clk), .rst_i(rst), .clear_i(clr1), .bus(b1.slave)
  );
  hci_mem_bank_responder #(.DW(32), .AW(10), .IW(20), .LATENCY(3), .STALL_PERIOD(255)) u_l3 (
    .clk_i(clk), .rst_i(rst), .clear_i(clr3), .bus(b3.slave)
  );
  hci_mem_bank_responder #(.DW(32), .AW(10), .IW(20), .LATENCY(2), .STALL_PERIOD(255)) u_l2 (
    .clk_i(clk), .rst_i(rst), .clear_i(clr2), .bus(b2.slave)
  );

`ifdef HCI_MEM_RESP_STALL_EN
  logic clrs;
  hci_mem_bank_responder_if #(.DW(32), .AW(10), .IW(20)) bs ();
  hci_mem_bank_responder #(.DW(32), .AW(10), .IW(20), .LATENCY(1), .STALL_PERIOD(4)) u_st (
    .clk_i(clk), .rst_i(rst), .clear_i(clrs), .bus(bs.slave)
  );
`endif

  typedef struct {
    logic        req;
    logic        wen;
    logic [3:0]  be;
    logic [9:0]  add;
    logic [31:0] data;
    logic [19:0] id;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vt [13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv1(input logic req, input logic wen, input logic [3:0] be,
                      input logic [9:0] add, input logic [31:0] data, input logic [19:0] id);
    b1.req = req; b1.wen = wen; b1.be = be; b1.add = add; b1.data = data; b1.id = id;
  endtask

  task automatic drv3(input logic req, input logic wen, input logic [3:0] be,
                      input logic [9:0] add, input logic [31:0] data, input logic [19:0] id);
    b3.req = req; b3.wen = wen; b3.be = be; b3.add = add; b3.data = data; b3.id = id;
  endtask

  task automatic drv2(input logic req, input logic wen, input logic [3:0] be,
                      input logic [9:0] add, input logic [31:0] data, input logic [19:0] id);
    b2.req = req; b2.wen = wen; b2.be = be; b2.add = add; b2.data = data; b2.id = id;
  endtask

  // Requests are held high during reset to show they are never granted.
  task automatic do_reset();
    rst = 1'b1;
    drv1(1'b1, 1'b0, 4'hF, 10'd0, 32'h0, 20'h0);
    drv3(1'b1, 1'b0, 4'hF, 10'd0, 32'h0, 20'h0);
    drv2(1'b1, 1'b0, 4'hF, 10'd0, 32'h0, 20'h0);
`ifdef HCI_MEM_RESP_STALL_EN
    bs.req = 1'b1; bs.wen = 1'b0; bs.be = 4'h0; bs.add = '0; bs.data = '0; bs.id = '0;
`endif
    tick();
    tick();
    chk("rst_gnt_l1", b1.gnt, 1'b0);
    chk("rst_gnt_l3", b3.gnt, 1'b0);
    chk("rst_rvalid_l1", b1.r_valid, 1'b0);
    chk("rst_rdata_l1", b1.r_data, 32'h0);
    chk("rst_rid_l1", b1.r_id, 20'h0);
    chk("rst_rvalid_l2", b2.r_valid, 1'b0);
    chk("rst_rvalid_l3", b3.r_valid, 1'b0);
    drv1(1'b0, 1'b0, 4'h0, 10'd0, 32'h0, 20'h0);
    drv3(1'b0, 1'b0, 4'h0, 10'd0, 32'h0, 20'h0);
    drv2(1'b0, 1'b0, 4'h0, 10'd0, 32'h0, 20'h0);
`ifdef HCI_MEM_RESP_STALL_EN
    bs.req = 1'b0;
`endif
    rst = 1'b0;
  endtask

  initial begin
    int resp_cnt;
    rst  = 1'b1;
    clr1 = 1'b0; clr3 = 1'b0; clr2 = 1'b0;
`ifdef HCI_MEM_RESP_STALL_EN
    clrs = 1'b0;
`endif

    vt[0]  = '{1'b1, 1'b0, 4'hF, 10'h005, 32'hDEADBEEF, 20'h00011, 32'h0};
    vt[1]  = '{1'b1, 1'b1, 4'h0, 10'h005, 32'h0,        20'h00012, 32'hDEADBEEF};
    vt[2]  = '{1'b1, 1'b0, 4'hF, 10'h007, 32'h11223344, 20'h00021, 32'h0};
    vt[3]  = '{1'b1, 1'b0, 4'h5, 10'h007, 32'hAABBCCDD, 20'h00022, 32'h0};
    vt[4]  = '{1'b1, 1'b1, 4'h0, 10'h007, 32'h0,        20'h00023, 32'h11BB33DD};
    vt[5]  = '{1'b1, 1'b0, 4'hF, 10'h3FF, 32'hCAFEF00D, 20'h00001, 32'h0};
    vt[6]  = '{1'b1, 1'b0, 4'h8, 10'h3FF, 32'h01020304, 20'h00002, 32'h0};
    vt[7]  = '{1'b1, 1'b1, 4'h0, 10'h3FF, 32'h0,        20'hFFFFF, 32'h01FEF00D};
    vt[8]  = '{1'b0, 1'b0, 4'hF, 10'h005, 32'h0,        20'h00055, 32'h0};
    vt[9]  = '{1'b1, 1'b1, 4'h0, 10'h005, 32'h0,        20'hABCDE, 32'hDEADBEEF};
    vt[10] = '{1'b1, 1'b0, 4'h0, 10'h005, 32'h0,        20'h00007, 32'h0};
    vt[11] = '{1'b1, 1'b1, 4'h0, 10'h005, 32'h0,        20'h00008, 32'hDEADBEEF};
    vt[12] = '{1'b1, 1'b1, 4'h0, 10'h3FF, 32'h0,        20'h12345, 32'h01FEF00D};

    do_reset();

    // LATENCY=1 table: apply back-to-back, response lands one cycle later.
    for (int i = 0; i < 13; i++) begin
      drv1(vt[i].req, vt[i].wen, vt[i].be, vt[i].add, vt[i].data, vt[i].id);
      #1;
      chk($sformatf("l1_gnt[%0d]", i), b1.gnt, vt[i].req);
      tick();
      chk($sformatf("l1_rvalid[%0d]", i), b1.r_valid, vt[i].req);
      chk($sformatf("l1_rid[%0d]", i), b1.r_id, vt[i].req ? vt[i].id : 20'h0);
      chk($sformatf("l1_rdata[%0d]", i), b1.r_data, vt[i].exp_data);
    end
    drv1(1'b0, 1'b0, 4'h0, 10'd0, 32'h0, 20'h0);
    tick();
    chk("l1_idle_rvalid", b1.r_valid, 1'b0);

    // LATENCY=3 back-to-back reads with ids 1..4.
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      drv3(1'b1, 1'b0, 4'hF, 10'(k), 32'h10000000 + k, 20'h00100 + 20'(k));
      tick();
    end
    drv3(1'b0, 1'b0, 4'h0, 10'd0, 32'h0, 20'h0);
    repeat (4) tick();
    for (int cyc = 0; cyc < 9; cyc++) begin
      int  k;
      logic ev;
      if (cyc < 4) drv3(1'b1, 1'b1, 4'h0, 10'(cyc + 1), 32'h0, 20'(cyc + 1));
      else         drv3(1'b0, 1'b0, 4'h0, 10'd0, 32'h0, 20'h0);
      #1;
      if (cyc < 4) chk($sformatf("l3_gnt[%0d]", cyc), b3.gnt, 1'b1);
      tick();
      k  = cyc - 2;
      ev = (k >= 0 && k < 4);
      chk($sformatf("l3_rvalid[%0d]", cyc), b3.r_valid, ev);
      chk($sformatf("l3_rid[%0d]", cyc), b3.r_id, ev ? 20'(k + 1) : 20'h0);
      chk($sformatf("l3_rdata[%0d]", cyc), b3.r_data, ev ? 32'h10000000 + 32'(k + 1) : 32'h0);
    end

    // Reset with two reads in flight on LATENCY=3; memory survives.
    drv3(1'b1, 1'b0, 4'hF, 10'd9, 32'h5A5A5A5A, 20'h00090);
    tick();
    drv3(1'b0, 1'b0, 4'h0, 10'd0, 32'h0, 20'h0);
    repeat (3) tick();
    drv3(1'b1, 1'b1, 4'h0, 10'd9, 32'h0, 20'h00091);
    tick();
    drv3(1'b1, 1'b1, 4'h0, 10'd9, 32'h0, 20'h00092);
    tick();
    drv3(1'b0, 1'b0, 4'h0, 10'd0, 32'h0, 20'h0);
    rst = 1'b1;
    tick();
    chk("rstfl_rvalid_a", b3.r_valid, 1'b0);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("rstfl_rvalid[%0d]", c), b3.r_valid, 1'b0);
      tick();
    end
    drv3(1'b1, 1'b1, 4'h0, 10'd9, 32'h0, 20'h00093);
    tick();
    drv3(1'b0, 1'b0, 4'h0, 10'd0, 32'h0, 20'h0);
    chk("rstfl_early1", b3.r_valid, 1'b0);
    tick();
    chk("rstfl_early2", b3.r_valid, 1'b0);
    tick();
    chk("rstfl_rvalid_after", b3.r_valid, 1'b1);
    chk("rstfl_rdata_after", b3.r_data, 32'h5A5A5A5A);
    chk("rstfl_rid_after", b3.r_id, 20'h00093);

    // LATENCY=2 soft clear with one response in flight.
    do_reset();
    drv2(1'b1, 1'b0, 4'hF, 10'd2, 32'h12345678, 20'h00070);
    tick();
    drv2(1'b0, 1'b0, 4'h0, 10'd0, 32'h0, 20'h0);
    repeat (3) tick();
    drv2(1'b1, 1'b1, 4'h0, 10'd2, 32'h0, 20'h00077);
    tick();
    clr2 = 1'b1;
    drv2(1'b1, 1'b1, 4'h0, 10'd2, 32'h0, 20'h0007F);
    #1;
    chk("clr_gnt", b2.gnt, 1'b0);
    tick();
    clr2 = 1'b0;
    drv2(1'b0, 1'b0, 4'h0, 10'd0, 32'h0, 20'h0);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("clr_rvalid[%0d]", c), b2.r_valid, 1'b0);
      tick();
    end
    drv2(1'b1, 1'b1, 4'h0, 10'd2, 32'h0, 20'h00078);
    #1;
    chk("clr_gnt_after", b2.gnt, 1'b1);
    tick();
    drv2(1'b0, 1'b0, 4'h0, 10'd0, 32'h0, 20'h0);
    chk("clr_lat_early", b2.r_valid, 1'b0);
    tick();
    chk("clr_rvalid_after", b2.r_valid, 1'b1);
    chk("clr_rdata_after", b2.r_data, 32'h12345678);
    chk("clr_rid_after", b2.r_id, 20'h00078);

`ifdef HCI_MEM_RESP_STALL_EN
    // STALL_PERIOD=4: grant drops in cycles 3, 7, 11 after reset release.
    do_reset();
    resp_cnt = 0;
    for (int c = 0; c < 15; c++) begin
      if (c < 12) begin
        bs.req = 1'b1; bs.wen = 1'b0; bs.be = 4'h0; bs.add = '0; bs.data = '0; bs.id = 20'(c);
      end else begin
        bs.req = 1'b0;
      end
      #1;
      if (c < 12) chk($sformatf("stall_gnt[%0d]", c), bs.gnt, (c % 4) != 3);
      tick();
      if (bs.r_valid === 1'b1) resp_cnt++;
    end
    chk("stall_resp_count", 64'(resp_cnt), 64'd9);
`else
    resp_cnt = 0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
